multi_cycle_control: RTL

MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

---
 rtl/multi_cycle_control_pkg.sv | 49 ++++
 rtl/multi_cycle_control_opcode_decode.sv | 40 ++++
 rtl/multi_cycle_control.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/multi_cycle_control_pkg.sv
// ============================================================================
// Module  : multi_cycle_control_pkg
// Purpose : Shared CPU definitions: FSM state encoding, opcode constants,
//           ALU_OP codes and the instruction class produced by opcode_decode.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package multi_cycle_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_EXEC_R    = 4'd2,
        S_EXEC_ADDR = 4'd3,
        S_MEM_RD    = 4'd4,
        S_MEM_WR    = 4'd5,
        S_WB_R      = 4'd6,
        S_WB_LD     = 4'd7,
        S_BR_CBZ    = 4'd8,
        S_BR_B      = 4'd9,
        S_HALT      = 4'd10
    } state_e;

    typedef enum logic [2:0] {
        CLS_R       = 3'd0,
        CLS_LD      = 3'd1,
        CLS_ST      = 3'd2,
        CLS_CBZ     = 3'd3,
        CLS_B       = 3'd4,
        CLS_ILLEGAL = 3'd5
    } op_class_e;

    localparam logic [1:0]  c_alu_add    = 2'b00;
    localparam logic [1:0]  c_alu_pass_b = 2'b01;
    localparam logic [1:0]  c_alu_funct  = 2'b10;

    localparam logic [10:0] c_op_add  = 11'b10001011000;
    localparam logic [10:0] c_op_sub  = 11'b11001011000;
    localparam logic [10:0] c_op_and  = 11'b10001010000;
    localparam logic [10:0] c_op_orr  = 11'b10101010000;
    localparam logic [10:0] c_op_ldur = 11'b11111000010;
    localparam logic [10:0] c_op_stur = 11'b11111000000;
    localparam logic [7:0]  c_op_cbz  = 8'b10110100;
    localparam logic [5:0]  c_op_b    = 6'b000101;

endpackage

`default_nettype wire

// File: rtl/multi_cycle_control_opcode_decode.sv
// ============================================================================
// Module  : opcode_decode
// Purpose : Purely combinational classifier of a 32-bit instruction word.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module opcode_decode
    import multi_cycle_control_pkg::*;
(
    input  logic [31:0] i_instruction,
    output op_class_e   o_class
);

    logic [10:0] w_op11;
    logic        w_unused;

    assign w_op11   = i_instruction[31:21];
    // Operand fields are irrelevant to classification.
    assign w_unused = ^i_instruction[20:0];

    always_comb begin
        o_class = CLS_ILLEGAL;
        if ((w_op11 == c_op_add) || (w_op11 == c_op_sub) ||
            (w_op11 == c_op_and) || (w_op11 == c_op_orr)) begin
            o_class = CLS_R;
        end else if (w_op11 == c_op_ldur) begin
            o_class = CLS_LD;
        end else if (w_op11 == c_op_stur) begin
            o_class = CLS_ST;
        end else if (i_instruction[31:24] == c_op_cbz) begin
            o_class = CLS_CBZ;
        end else if (i_instruction[31:26] == c_op_b) begin
            o_class = CLS_B;
        end
    end

endmodule

`default_nettype wire

// File: rtl/multi_cycle_control.sv
// ============================================================================
// Module  : multi_cycle_control
// Purpose : Multi-cycle CPU control FSM generating datapath strobes per state.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_cycle_control
    import multi_cycle_control_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic        imem_ready,
    input  logic        mem_ready,
    input  logic        ZERO_FLAG,
    output logic        IR_WRITE,
    output logic        PC_WRITE,
    output logic        PC_SRC,
    output logic        REG2LOC,
    output logic        ALU_SRC,
    output logic        MEM2REG,
    output logic        REG_WRITE,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [1:0]  ALU_OP,
    output logic [3:0]  state,
    output logic        inst_done,
    output logic        halted
);

    state_e    r_state_q;
    state_e    w_state_d;
    op_class_e w_class;

    opcode_decode u_opcode_decode (
        .i_instruction (instruction),
        .o_class       (w_class)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= S_FETCH;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    assign state = r_state_q;

    // Outputs are gated by rst so that even FETCH's IR_WRITE drops while in reset.
    always_comb begin
        w_state_d = r_state_q;
        IR_WRITE  = 1'b0;
        PC_WRITE  = 1'b0;
        PC_SRC    = 1'b0;
        REG2LOC   = 1'b0;
        ALU_SRC   = 1'b0;
        MEM2REG   = 1'b0;
        REG_WRITE = 1'b0;
        MEM_READ  = 1'b0;
        MEM_WRITE = 1'b0;
        ALU_OP    = c_alu_add;
        inst_done = 1'b0;
        halted    = 1'b0;
        if (!rst) begin
            case (r_state_q)
                S_FETCH: begin
                    IR_WRITE = imem_ready;
                    if (imem_ready) w_state_d = S_DECODE;
                end
                S_DECODE: begin
                    case (w_class)
                        CLS_R:   w_state_d = S_EXEC_R;
                        CLS_LD,
                        CLS_ST:  w_state_d = S_EXEC_ADDR;
                        CLS_CBZ: w_state_d = S_BR_CBZ;
                        CLS_B:   w_state_d = S_BR_B;
                        default: begin
                            if (HALT_ON_ILLEGAL) begin
                                w_state_d = S_HALT;
                            end else begin
                                PC_WRITE  = 1'b1;
                                inst_done = 1'b1;
                                w_state_d = S_FETCH;
                            end
                        end
                    endcase
                end
                S_EXEC_R: begin
                    ALU_OP    = c_alu_funct;
                    w_state_d = S_WB_R;
                end
                S_WB_R: begin
                    ALU_OP    = c_alu_funct;
                    REG_WRITE = 1'b1;
                    PC_WRITE  = 1'b1;
                    inst_done = 1'b1;
                    w_state_d = S_FETCH;
                end
                S_EXEC_ADDR: begin
                    ALU_SRC   = 1'b1;
                    REG2LOC   = 1'b1;
                    w_state_d = (w_class == CLS_LD) ? S_MEM_RD : S_MEM_WR;
                end
                S_MEM_RD: begin
                    MEM_READ = 1'b1;
                    ALU_SRC  = 1'b1;
                    if (mem_ready) w_state_d = S_WB_LD;
                end
                S_WB_LD: begin
                    REG_WRITE = 1'b1;
                    MEM2REG   = 1'b1;
                    PC_WRITE  = 1'b1;
                    inst_done = 1'b1;
                    w_state_d = S_FETCH;
                end
                S_MEM_WR: begin
                    MEM_WRITE = 1'b1;
                    REG2LOC   = 1'b1;
                    ALU_SRC   = 1'b1;
                    if (mem_ready) begin
                        PC_WRITE  = 1'b1;
                        inst_done = 1'b1;
                        w_state_d = S_FETCH;
                    end
                end
                S_BR_CBZ: begin
                    REG2LOC   = 1'b1;
                    ALU_OP    = c_alu_pass_b;
                    PC_WRITE  = 1'b1;
                    PC_SRC    = ZERO_FLAG;
                    inst_done = 1'b1;
                    w_state_d = S_FETCH;
                end
                S_BR_B: begin
                    PC_WRITE  = 1'b1;
                    PC_SRC    = 1'b1;
                    inst_done = 1'b1;
                    w_state_d = S_FETCH;
                end
                S_HALT: begin
                    halted = 1'b1;
                end
                default: begin
                    w_state_d = S_FETCH;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
